// File: rtl/rng_stream.sv
// Filtered Galois-LFSR random sample stream with a small FIFO.
// Ports: clk, rst_n, enable, seed_load/seed_in, out_ready -> out_valid, out_data, level, reject_cnt.
module rng_stream #(
    parameter int          WIDTH   = 16,
    parameter int          OUT_W   = 4,
    parameter int          MAX_VAL = 9,
    parameter int          DEPTH   = 4,
    parameter logic [31:0] SEED    = 32'h0000_ACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     seed_load,
    input  logic [WIDTH-1:0]         seed_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              reject_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [31:0] TAPS32 =
        (WIDTH == 8)  ? 32'h0000_00B8 :
        (WIDTH == 16) ? 32'h0000_B400 :
        (WIDTH == 24) ? 32'h00E1_0000 :
                        32'hA300_0000;

    localparam logic [WIDTH-1:0] TAPS    = TAPS32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W  = SEED[WIDTH-1:0];
    localparam logic [OUT_W-1:0] MAX_W   = MAX_VAL[OUT_W-1:0];
    localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
        $error("rng_stream: WIDTH must be 8, 16, 24 or 32");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
        $error("rng_stream: OUT_W must be in 1..WIDTH");
    end
    if (MAX_VAL < 0 || (OUT_W < 31 && MAX_VAL >= (1 << OUT_W))) begin : g_bad_max
        $error("rng_stream: MAX_VAL must be below 2**OUT_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rng_stream: DEPTH must be a power of two >= 2");
    end
    if (SEED_W == '0) begin : g_bad_seed
        $error("rng_stream: SEED must be nonzero after sizing to WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [15:0]      rej_q, rej_d;

    state_e           state;
    logic             full;
    logic             empty;
    logic [OUT_W-1:0] cand;
    logic             accept;
    logic             step;
    logic             push;
    logic             pop;

    assign full   = (level_q == DEPTH_L);
    assign empty  = (level_q == '0);
    assign cand   = lfsr_q[OUT_W-1:0];
    assign accept = (cand <= MAX_W);

    // Control state is purely a function of enable and fill level.
    always_comb begin
        state = IDLE;
        if (enable) begin
            state = full ? STALL : RUN;
        end
    end

    // Stepping looks at the pre-pop level, so a pop from a full
    // buffer only frees a slot for the following cycle.
    assign step = (state == RUN) && !seed_load;
    assign push = step && accept;
    assign pop  = !empty && out_ready && !seed_load;

    always_comb begin
        lfsr_d   = lfsr_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rej_d    = rej_q;

        if (seed_load) begin
            lfsr_d   = (seed_in != '0) ? seed_in : SEED_W;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            rej_d    = '0;
        end else begin
            if (step) begin
                lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
                if (!accept && rej_q != 16'hFFFF) begin
                    rej_d = rej_q + 16'd1;
                end
            end
            if (push) begin
                mem_d[wr_ptr_q] = cand;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q   <= SEED_W;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rej_q    <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rej_q    <= rej_d;
        end
    end

    assign out_valid  = !empty;
    assign out_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign level      = level_q;
    assign reject_cnt = rej_q;

endmodule

// File: tb/tb_rng_stream.sv
// Self-checking bench for rng_stream: vector table, corner sequences,
// random traffic against a queue-based reference, and an 8-bit period run.
module tb_rng_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [2:0]  level;
    logic [15:0] reject_cnt;

    logic        rst8_n;
    logic        en8;
    logic        v8;
    logic [7:0]  d8;
    logic [2:0]  l8;
    logic [15:0] r8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rng_stream dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .level(level), .reject_cnt(reject_cnt)
    );

    rng_stream #(.WIDTH(8), .OUT_W(8), .MAX_VAL(255), .DEPTH(4)) dut8 (
        .clk(clk), .rst_n(rst8_n), .enable(en8), .seed_load(1'b0),
        .seed_in(8'h00), .out_ready(1'b1), .out_valid(v8),
        .out_data(d8), .level(l8), .reject_cnt(r8)
    );

    // Reference model: sample queue plus current LFSR word and reject count.
    logic [15:0] m_lfsr;
    logic [15:0] m_rej;
    logic [3:0]  m_q [$];

    function automatic logic [15:0] nxt16(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [7:0] nxt8(input logic [7:0] x);
        return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_lfsr = 16'hACE1;
        m_rej  = 16'd0;
    endtask

    task automatic model_step();
        bit do_pop;
        bit do_step;
        logic [3:0] c;
        if (seed_load) begin
            m_q.delete();
            m_lfsr = (seed_in == 16'd0) ? 16'hACE1 : seed_in;
            m_rej  = 16'd0;
        end else begin
            do_pop  = (m_q.size() > 0) && out_ready;
            do_step = enable && (m_q.size() < 4);
            c = m_lfsr[3:0];
            if (do_pop) void'(m_q.pop_front());
            if (do_step) begin
                if (c <= 4'd9) m_q.push_back(c);
                else if (m_rej != 16'hFFFF) m_rej = m_rej + 16'd1;
                m_lfsr = nxt16(m_lfsr);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        logic [3:0] hd;
        hd = (m_q.size() > 0) ? m_q[0] : 4'd0;
        check({name, ".valid"}, 32'(out_valid), 32'(m_q.size() > 0));
        check({name, ".data"},  32'(out_data),  32'(hd));
        check({name, ".level"}, 32'(level),     32'(m_q.size()));
        check({name, ".rej"},   32'(reject_cnt), 32'(m_rej));
    endtask

    task automatic tick(input string name);
        model_step();
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    task automatic drive(input logic en, input logic rdy, input logic sl,
                         input logic [15:0] sd);
        enable    = en;
        out_ready = rdy;
        seed_load = sl;
        seed_in   = sd;
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        sl;
        logic [15:0] seed;
        logic        ev;
        logic [3:0]  ed;
        logic [2:0]  el;
        logic [15:0] er;
    } vec_t;

    vec_t tbl [8];

    logic [7:0] vals [256];
    bit         seen [256];
    bit         dup;

    initial begin
        rst_n  = 1'b0;
        rst8_n = 1'b0;
        en8    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        model_reset();

        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 4'd1, 3'd1, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 4'd0, 3'd1, 16'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 4'd8, 3'd1, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 4'd0, 3'd0, 16'd1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 4'd0, 3'd0, 16'd2};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 4'd7, 3'd1, 16'd2};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 16'h0, 1'b0, 4'd0, 3'd0, 16'd0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 4'd1, 3'd1, 16'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", 32'(out_valid), 32'd0);
        check("reset.data",  32'(out_data),  32'd0);
        check("reset.level", 32'(level),     32'd0);
        check("reset.rej",   32'(reject_cnt), 32'd0);

        // 8-bit LFSR period: output stream is the raw state sequence.
        rst8_n = 1'b1;
        en8    = 1'b1;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            #1;
            vals[k] = d8;
        end
        en8 = 1'b0;
        check("p8.first", 32'(vals[0]), 32'hE1);
        begin
            logic [7:0] s;
            int nbad;
            s = 8'hE1;
            nbad = 0;
            for (int k = 0; k < 256; k++) begin
                if (vals[k] !== s) nbad++;
                s = nxt8(s);
            end
            check("p8.sequence", 32'(nbad), 32'd0);
        end
        dup = 1'b0;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 255; k++) begin
            if (seen[vals[k]]) dup = 1'b1;
            seen[vals[k]] = 1'b1;
        end
        check("p8.no_early_repeat", 32'(dup), 32'd0);
        check("p8.wrap", 32'(vals[255]), 32'(vals[0]));

        // Vector table from cold start.
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].en, tbl[i].rdy, tbl[i].sl, tbl[i].seed);
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
            check($sformatf("vec%0d.data", i),  32'(out_data),  32'(tbl[i].ed));
            check($sformatf("vec%0d.level", i), 32'(level),     32'(tbl[i].el));
            check($sformatf("vec%0d.rej", i),   32'(reject_cnt), 32'(tbl[i].er));
        end

        // Push and pop on the same edge at level 2.
        drive(1'b0, 1'b0, 1'b1, 16'h0);
        tick("pp.seed");
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tick("pp.fill1");
        tick("pp.fill2");
        check("pp.level2", 32'(level), 32'd2);
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tick("pp.both");
        check("pp.both.level", 32'(level), 32'd2);
        check("pp.both.head", 32'(out_data), 32'd0);
        tick("pp.next");
        check("pp.next.head", 32'(out_data), 32'd8);
        check("pp.next.level", 32'(level), 32'd1);

        // Fill to full, stall, single pop, resume next cycle.
        drive(1'b0, 1'b0, 1'b1, 16'h0);
        tick("st.seed");
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) tick("st.fill");
        check("st.full", 32'(level), 32'd4);
        check("st.frozen_rej", 32'(reject_cnt), 32'd2);
        check("st.head", 32'(out_data), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tick("st.pop");
        check("st.pop.level", 32'(level), 32'd3);
        check("st.pop.head", 32'(out_data), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tick("st.resume");
        check("st.resume.level", 32'(level), 32'd4);

        // Reseed with zero while level 3 falls back to the default seed.
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tick("sl.pop");
        check("sl.level3", 32'(level), 32'd3);
        drive(1'b1, 1'b0, 1'b1, 16'h0);
        tick("sl.load");
        check("sl.level", 32'(level), 32'd0);
        check("sl.valid", 32'(out_valid), 32'd0);
        check("sl.rej", 32'(reject_cnt), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        tick("sl.first");
        check("sl.first.data", 32'(out_data), 32'd1);

        // Asynchronous reset pulse mid-cycle at level 2.
        tick("ar.fill");
        check("ar.level2", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.valid", 32'(out_valid), 32'd0);
        check("ar.level", 32'(level), 32'd0);
        check("ar.data", 32'(out_data), 32'd0);
        check("ar.rej", 32'(reject_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 1'b1, 1'b0, 16'h0);
        tick("ar.cold");
        check("ar.cold.data", 32'(out_data), 32'd1);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic sl;
            logic [15:0] sd;
            sl = ($urandom_range(0, 63) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), sl, sd);
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
